handshake_rx: RTL

Receive end of the four-phase req/ack CDC handshake for slow-domain capture of fast-domain words. Lives in the r_clk domain. Synchronizes the incoming req level and captures the held data bus, returning a level ack. Presents each word downstream on a one-entry valid/ready buffer. Stalls ack while the buffer is occupied, giving the transmitter end-to-end backpressure.

---
 rtl/handshake_rx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/handshake_rx.sv
// Receive end of a four-phase req/ack CDC handshake in the r_clk domain,
// presenting each captured word on a one-entry valid/ready buffer.
// Optional build macro HANDSHAKE_RX_STATS_EN adds xfer_cnt/stall_cnt outputs.
module handshake_rx #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic              r_clk,
    input  logic              rst_n,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef HANDSHAKE_RX_STATS_EN
    ,
    output logic [15:0]       xfer_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    state_e                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;

    logic                   buf_free;
    logic                   capture;
    logic                   stall;

    // req_in is only ever seen through this chain; data_in needs no
    // synchronizer because it has been stable for SYNC_STAGES edges at capture.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_s    = sync_q[SYNC_STAGES-1];
    assign buf_free = !valid_q || out_ready;

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: every signal is given a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        data_d  = data_q;
        valid_d = valid_q;
        capture = 1'b0;
        stall   = 1'b0;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (req_s && buf_free) begin
                    capture = 1'b1;
                    data_d  = data_in;
                    valid_d = 1'b1;   // overrides a same-edge consume
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end else if (req_s) begin
                    stall = 1'b1;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    assign ack_out   = ack_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

`ifdef HANDSHAKE_RX_STATS_EN
    logic [15:0] xfer_q, stall_q;

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            if (capture && xfer_q != 16'hFFFF) begin
                xfer_q <= xfer_q + 16'd1;
            end
            if (stall && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign xfer_cnt  = xfer_q;
    assign stall_cnt = stall_q;
`else
    logic unused_stats;
    assign unused_stats = capture ^ stall;
`endif

endmodule
